bus_master_ctrl: RTL
====================

Name: bus_master_ctrl

Overview:
Per-master bus sequencer placed between a simple core-side access port (CPU I/F or DMA) and one master slot of the shared 4-master/8-slave bus.
Converts a single-cycle-intent request into the bus protocol: request, wait for grant, address strobe, wait for slave ready.
Stalls the requester until the transfer completes, returns read data, and enforces a ready timeout with an error pulse.
One instance per bus master.

Parameters:
ADDR_W, 30, word address width (matches bus word address bus)
DATA_W, 32, data width (matches bus word data bus)
TIMEOUT, 16, max cycles from address strobe to slave ready; 0 disables timeout
CNT_W, 5, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cReq  in  1  core access request, level; held until cStall low
cAddr  in  ADDR_W  core word address
cRW  in  1  1 = read, 0 = write
cWrData  in  DATA_W  core write data
cRdData  out  DATA_W  read data; valid in the DONE cycle, held until the next completion
cStall  out  1  combinational: cReq & (state != DONE)
cErr  out  1  one-cycle pulse in DONE when the transfer timed out
busReq_  out  1  bus request to arbiter, active low
busGrnt_  in  1  grant from arbiter, active low
busAddr  out  ADDR_W  address to master mux
busAs_  out  1  address strobe, active low
busRW  out  1  read/write to master mux
busWrData  out  DATA_W  write data to master mux
busRdData  in  DATA_W  shared read data from slave mux
busRdy_  in  1  shared slave ready, active low

Behaviour:
- Clock, reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state = IDLE, busReq_ = 1, busAs_ = 1, busAddr/busRW/busWrData = 0, cRdData = 0, cErr = 0, counter = 0.
- Reset mid-transfer: on the next edge, return to IDLE and release the bus; no completion is signalled.
- Registered latches: addrQ, rwQ, wdQ capture cAddr, cRW, cWrData on IDLE→REQ.
- Bus drive:
  - busAddr, busRW and busWrData equal the latched values while state ∈ {REQ, ACCESS, WAIT}; otherwise 0.
  - busReq_ = 0 in REQ, ACCESS and WAIT.
  - busAs_ = 0 only in ACCESS.
- FSM:
  - IDLE: if cReq, go to REQ; else stay.
  - REQ: if busGrnt_ == 0, go to ACCESS. busRdy_ is ignored (it may belong to another master).
  - ACCESS: exactly one cycle; counter is cleared. If busRdy_ == 0, complete. Else go to WAIT.
  - WAIT: counter increments each cycle.
    - If busRdy_ == 0, complete normally.
    - Else if TIMEOUT != 0 and counter == TIMEOUT-1, complete with error.
    - If Rdy_ and timeout hit in the same cycle, Rdy_ wins (normal completion).
  - Complete, normal: go to DONE; if rwQ = read, cRdData <= busRdData; writes leave cRdData unchanged.
  - Complete, error: go to DONE; cErr <= 1; cRdData <= 0.
  - DONE: one cycle. busReq_ = 1, cStall = 0, cErr as set. Always go to IDLE.
- Latency, immediate grant and zero-wait slave: cReq seen in IDLE at cycle 0 → REQ at cycle 1 → ACCESS at cycle 2 → DONE at cycle 3. cStall is high in cycles 0–2 and low in cycle 3.
- Back-to-back requests: a new request is accepted in IDLE one cycle after DONE, so throughput is at most one transfer per 4 cycles.
- cReq dropped mid-transfer: the transfer still completes on the bus (no abort); cStall follows cReq.
- Grant removed after ACCESS: ignored, because the arbiter holds grant while busReq_ is low.
- Timeout count: the number of WAIT cycles before error is TIMEOUT-1, i.e. TIMEOUT cycles after ACCESS.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding (IDLE = 0, REQ = 1, ACCESS = 2, WAIT = 3, DONE = 4; 3-bit)
  - READ = 1 / WRITE = 0
  - ENABLE_ = 0 / DISABLE_ = 1
  - ADDR_W / DATA_W defaults
- Natural sub-module: bus_timeout_cnt, a clear/enable counter with a terminal-count flag.
- The FSM and latches stay in bus_master_ctrl.

Test Plan:
- Read, grant immediate, busRdy_ low in ACCESS, busRdData = 0xDEADBEEF, cAddr = 0x0000100 → busAs_ low exactly cycle 2, busAddr = 0x0000100, DONE cycle 3, cRdData = 0xDEADBEEF, cErr = 0.
- Write, cWrData = 0x12345678, grant delayed 5 cycles → busReq_ low from cycle 1, busAs_ low cycle 7 only, busWrData = 0x12345678, busRW = 0, cStall high until DONE.
- Read, slave ready after 3 WAIT cycles → DONE at cycle 6, data captured from the Rdy_ cycle only; busRdy_ pulses during REQ are ignored.
- TIMEOUT = 16, slave never ready → DONE 16 cycles after ACCESS, cErr single pulse, cRdData = 0, busReq_ released.
- busRdy_ asserted on the timeout cycle → normal completion, cErr = 0.
- Reset asserted in WAIT → next cycle busReq_ = 1, busAs_ = 1, state IDLE, no cErr; a subsequent read completes correctly.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus master sequencer:
// FSM state encoding, bus polarity constants and width defaults.
package bus_pkg;

    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // The master owns the bus (request held, address driven) in these states.
    function automatic logic bus_active(input state_e s);
        return (s == ST_REQ) || (s == ST_ACCESS) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Slave-ready timeout counter: clear/enable up-counter with a terminal flag.
// Ports: clk, reset (sync, active-high), clr_i, en_i, tc_o (count reached TIMEOUT-1).
module bus_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] LAST_C = LAST[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // TIMEOUT == 0 disables the flag entirely.
    assign tc_o = (TIMEOUT != 0) && (cnt_q >= LAST_C);

endmodule

// File: rtl/bus_master_ctrl.sv
// Per-master bus sequencer: core request -> bus request/grant/strobe/ready.
// Ports: core side cReq/cAddr/cRW/cWrData/cRdData/cStall/cErr;
// bus side busReq_/busGrnt_/busAddr/busAs_/busRW/busWrData/busRdData/busRdy_.
module bus_master_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cReq,
    input  logic [ADDR_W-1:0] cAddr,
    input  logic              cRW,
    input  logic [DATA_W-1:0] cWrData,
    output logic [DATA_W-1:0] cRdData,
    output logic              cStall,
    output logic              cErr,
    output logic              busReq_,
    input  logic              busGrnt_,
    output logic [ADDR_W-1:0] busAddr,
    output logic              busAs_,
    output logic              busRW,
    output logic [DATA_W-1:0] busWrData,
    input  logic [DATA_W-1:0] busRdData,
    input  logic              busRdy_
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              err_q, err_d;

    logic              busReq_q;
    logic              busAs_q;
    logic [ADDR_W-1:0] busAddr_q;
    logic              busRW_q;
    logic [DATA_W-1:0] busWrData_q;

    logic cnt_en;
    logic cnt_tc;

    // Counter runs from the ACCESS cycle on, so it reads 0 in ACCESS
    // and N in the N-th WAIT cycle.
    assign cnt_en = (state_q == ST_ACCESS) || (state_q == ST_WAIT);

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clr_i (!cnt_en),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cReq) begin
                    state_d = ST_REQ;
                    addr_d  = cAddr;
                    rw_d    = cRW;
                    wd_d    = cWrData;
                end
            end
            ST_REQ: begin
                // busRdy_ here may belong to another master.
                if (busGrnt_ == ENABLE_) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (busRdy_ == ENABLE_) begin
                    state_d = ST_DONE;
                    if (rw_q == READ) begin
                        rd_d = busRdData;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ready wins over a simultaneous timeout.
                if (busRdy_ == ENABLE_) begin
                    state_d = ST_DONE;
                    if (rw_q == READ) begin
                        rd_d = busRdData;
                    end
                end else if (cnt_tc) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rd_d    = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are registered from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rw_q        <= WRITE;
            wd_q        <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            busReq_q    <= DISABLE_;
            busAs_q     <= DISABLE_;
            busAddr_q   <= '0;
            busRW_q     <= WRITE;
            busWrData_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wd_q        <= wd_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            busReq_q    <= bus_active(state_d) ? ENABLE_ : DISABLE_;
            busAs_q     <= (state_d == ST_ACCESS) ? ENABLE_ : DISABLE_;
            busAddr_q   <= bus_active(state_d) ? addr_d : '0;
            busRW_q     <= bus_active(state_d) ? rw_d : WRITE;
            busWrData_q <= bus_active(state_d) ? wd_d : '0;
        end
    end

    assign cStall    = cReq & (state_q != ST_DONE);
    assign cRdData   = rd_q;
    assign cErr      = err_q;
    assign busReq_   = busReq_q;
    assign busAs_    = busAs_q;
    assign busAddr   = busAddr_q;
    assign busRW     = busRW_q;
    assign busWrData = busWrData_q;

endmodule
